// File: rtl/conv2d_stream_pkg.sv
// Shared helpers for the streaming KxK convolution engine: width math,
// default coefficient table and the per-stage pipeline control record.
package conv2d_stream_pkg;

    // Valid/last tag carried alongside each pipeline stage.
    typedef struct packed {
        logic valid;
        logic last;
    } stage_ctl_t;

    // Ceiling log2, never smaller than 1 so it can size any index port.
    function automatic int clog2(input int value);
        int result;
        int span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span * 2;
            result = result + 1;
        end
        if (result == 0) begin
            result = 1;
        end
        return result;
    endfunction

    // Narrowest accumulator that can hold K*K full-scale products.
    function automatic int min_acc_w(input int data_w, input int coef_w, input int k);
        return data_w + coef_w + clog2(k * k);
    endfunction

    // Reset coefficient: 2,1,2 / 1,2,1 / 2,1,2 for K=3, otherwise a unit centre tap.
    function automatic logic [31:0] default_coef(input int k, input int idx);
        logic [31:0] value;
        if (k == 3) begin
            value = ((idx % 2) == 0) ? 32'd2 : 32'd1;
        end else if (idx == ((k / 2) * k + (k / 2))) begin
            value = 32'd1;
        end else begin
            value = 32'd0;
        end
        return value;
    endfunction

endpackage

// File: rtl/conv2d_stream_line_buffer.sv
// One-line pixel delay: a circular RAM of IMG_W entries with a single
// read/write pointer. The output is the pixel written IMG_W accepts earlier.
// Contents are never cleared; callers mask stale data with their counters.
module conv2d_stream_line_buffer
    import conv2d_stream_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    localparam int PTR_W = clog2(IMG_W);

    logic [DATA_W-1:0] mem_r [IMG_W];
    logic [PTR_W-1:0]  ptr_r;

    // Old entry is read out at the slot that is about to be overwritten.
    assign dout = mem_r[ptr_r];

    // Storage write: replace the oldest pixel with the incoming one.
    always_ff @(posedge clk) begin
        if (en) begin
            mem_r[ptr_r] <= din;
        end
    end

    // Circular pointer, wraps after the last pixel of a line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r <= '0;
        end else if (en) begin
            if (ptr_r == PTR_W'(IMG_W - 1)) begin
                ptr_r <= '0;
            end else begin
                ptr_r <= ptr_r + PTR_W'(1);
            end
        end
    end

endmodule

// File: rtl/conv2d_stream.sv
// Streaming KxK 2-D convolution over raster-scan pixels with programmable
// coefficients. Three stages: window update, registered products, adder tree.
// A full output register back-pressures the whole pipeline and the source.
module conv2d_stream
    import conv2d_stream_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int K      = 3,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int ACC_W  = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    coef_we,
    input  logic [clog2(K*K)-1:0]   coef_addr,
    input  logic [COEF_W-1:0]       coef_data,
    input  logic                    pix_valid,
    output logic                    pix_ready,
    input  logic                    pix_sof,
    input  logic [DATA_W-1:0]       pix_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ACC_W-1:0]        out_data,
    output logic                    out_last
);

    localparam int NTAP   = K * K;
    localparam int ROW_W  = clog2(IMG_H);
    localparam int COL_W  = clog2(IMG_W);
    localparam int PROD_W = DATA_W + COEF_W;

    if (ACC_W < min_acc_w(DATA_W, COEF_W, K)) begin : g_acc_w_check
        $error("conv2d_stream: ACC_W too narrow for K*K products");
    end
    if ((K < 2) || (K > 7) || (IMG_W < K) || (IMG_H < K)) begin : g_geom_check
        $error("conv2d_stream: unsupported kernel or image geometry");
    end

    logic              stall_s;
    logic              accept_s;
    logic [ROW_W-1:0]  row_r, eff_row_s, next_row_s;
    logic [COL_W-1:0]  col_r, eff_col_s, next_col_s;
    logic              win_valid_s;
    logic              win_last_s;
    logic [DATA_W-1:0] lb_out_s  [K-1];
    logic [DATA_W-1:0] col_in_s  [K];
    logic [DATA_W-1:0] win_r     [K][K];
    logic [COEF_W-1:0] coef_r    [NTAP];
    logic [PROD_W-1:0] prod_r    [NTAP];
    logic [ACC_W-1:0]  sum_s;
    stage_ctl_t        s1_r;
    stage_ctl_t        s2_r;
    logic              out_valid_r;
    logic              out_last_r;
    logic [ACC_W-1:0]  out_data_r;

    // Only a full, unaccepted output holds the pipe.
    assign stall_s   = out_valid_r && !out_ready;
    assign pix_ready = !stall_s;
    assign accept_s  = pix_valid && !stall_s;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_last  = out_last_r;

    // K-1 chained one-line delays supply the pixels directly above.
    for (genvar i = 0; i < K - 1; i++) begin : g_lb
        logic [DATA_W-1:0] din_s;
        if (i == 0) begin : g_first
            assign din_s = pix_data;
        end else begin : g_chain
            assign din_s = lb_out_s[i-1];
        end
        conv2d_stream_line_buffer #(
            .DATA_W (DATA_W),
            .IMG_W  (IMG_W)
        ) u_lb (
            .clk  (clk),
            .rst  (rst),
            .en   (accept_s),
            .din  (din_s),
            .dout (lb_out_s[i])
        );
    end

    // Newest column of the window: bottom row is the live pixel, upper rows from line buffers.
    always_comb begin
        col_in_s[K-1] = pix_data;
        for (int i = 0; i < K - 1; i++) begin
            col_in_s[K-2-i] = lb_out_s[i];
        end
    end

    // Position of the incoming pixel, window qualification and next raster position.
    always_comb begin
        if (pix_sof) begin
            eff_row_s = '0;
            eff_col_s = '0;
        end else begin
            eff_row_s = row_r;
            eff_col_s = col_r;
        end
        win_valid_s = (eff_row_s >= ROW_W'(K - 1)) && (eff_col_s >= COL_W'(K - 1));
        win_last_s  = (eff_row_s == ROW_W'(IMG_H - 1)) && (eff_col_s == COL_W'(IMG_W - 1));
        if (eff_col_s == COL_W'(IMG_W - 1)) begin
            next_col_s = '0;
            if (eff_row_s == ROW_W'(IMG_H - 1)) begin
                next_row_s = '0;
            end else begin
                next_row_s = eff_row_s + ROW_W'(1);
            end
        end else begin
            next_col_s = eff_col_s + COL_W'(1);
            next_row_s = eff_row_s;
        end
    end

    // Raster counters advance on every accepted pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_r <= '0;
            col_r <= '0;
        end else if (accept_s) begin
            row_r <= next_row_s;
            col_r <= next_col_s;
        end
    end

    // Coefficient bank: defaults on reset, writes accepted even while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NTAP; i++) begin
                coef_r[i] <= COEF_W'(default_coef(K, i));
            end
        end else if (coef_we && (int'(coef_addr) < NTAP)) begin
            coef_r[coef_addr] <= coef_data;
        end
    end

    // S1: shift the window left and load the new column on each accepted pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    win_r[r][c] <= '0;
                end
            end
            s1_r <= '0;
        end else if (!stall_s) begin
            if (accept_s) begin
                for (int r = 0; r < K; r++) begin
                    for (int c = 0; c < K - 1; c++) begin
                        win_r[r][c] <= win_r[r][c+1];
                    end
                    win_r[r][K-1] <= col_in_s[r];
                end
            end
            s1_r.valid <= accept_s && win_valid_s;
            s1_r.last  <= accept_s && win_last_s;
        end
    end

    // S2: one registered product per tap using the current coefficients.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NTAP; i++) begin
                prod_r[i] <= '0;
            end
            s2_r <= '0;
        end else if (!stall_s) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    prod_r[r*K+c] <= PROD_W'(win_r[r][c]) * PROD_W'(coef_r[r*K+c]);
                end
            end
            s2_r <= s1_r;
        end
    end

    // Adder tree over all products, zero-extended to the output width.
    always_comb begin
        sum_s = '0;
        for (int i = 0; i < NTAP; i++) begin
            sum_s = sum_s + ACC_W'(prod_r[i]);
        end
    end

    // S3: output register; result and last flag only change when a new result lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_last_r  <= 1'b0;
        end else if (!stall_s) begin
            out_valid_r <= s2_r.valid;
            if (s2_r.valid) begin
                out_data_r <= sum_s;
                out_last_r <= s2_r.last;
            end
        end
    end

endmodule

// File: tb/tb_conv2d_stream.sv
// Self-checking bench for conv2d_stream (K=3, 4x4 frames). Expected results
// come from a direct sliding-window sum over each frame held in an array.
module tb_conv2d_stream;

    localparam int DATA_W = 8;
    localparam int COEF_W = 8;
    localparam int K      = 3;
    localparam int IMG_W  = 4;
    localparam int IMG_H  = 4;
    localparam int ACC_W  = 32;
    localparam int NPIX   = IMG_W * IMG_H;
    localparam int NTAP   = K * K;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              coef_we = 1'b0;
    logic [3:0]        coef_addr = 4'd0;
    logic [COEF_W-1:0] coef_data = 8'd0;
    logic              pix_valid = 1'b0;
    logic              pix_ready;
    logic              pix_sof = 1'b0;
    logic [DATA_W-1:0] pix_data = 8'd0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [ACC_W-1:0]  out_data;
    logic              out_last;

    conv2d_stream #(
        .DATA_W (DATA_W), .COEF_W (COEF_W), .K (K),
        .IMG_W  (IMG_W),  .IMG_H  (IMG_H),  .ACC_W (ACC_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_sof   (pix_sof),
        .pix_data  (pix_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          img [NPIX];
    int          coef_m [NTAP];
    longint      exp_q [$];
    bit          exp_last_q [$];
    int          ready_pct = 100;
    bit          stall_req = 1'b0;
    bit          stall_done = 1'b0;
    int          stall_left = 0;
    logic [31:0] held = 32'd0;
    bit          seen_first = 1'b0;
    int          first_cyc = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_default_coefs();
        for (int i = 0; i < NTAP; i++) coef_m[i] = ((i % 2) == 0) ? 2 : 1;
    endtask

    // Reference: every KxK window fully inside the frame, in raster order of its last pixel.
    task automatic push_expected();
        for (int r0 = 0; r0 <= IMG_H - K; r0++) begin
            for (int c0 = 0; c0 <= IMG_W - K; c0++) begin
                longint s = 0;
                for (int r = 0; r < K; r++)
                    for (int c = 0; c < K; c++)
                        s += longint'(coef_m[r*K+c]) * longint'(img[(r0+r)*IMG_W + c0 + c]);
                exp_q.push_back(s);
                exp_last_q.push_back((r0 == IMG_H - K) && (c0 == IMG_W - K));
            end
        end
    endtask

    task automatic pop_check();
        checks++;
        assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_result observed=%0d expected=none", out_data);
        end
        if (exp_q.size() != 0) begin
            chk("out_data", {32'd0, out_data}, exp_q.pop_front());
            chk("out_last", {63'd0, out_last}, {63'd0, exp_last_q.pop_front()});
        end
    endtask

    // One clock: drive, evaluate both handshakes before the edge, sample after it.
    task automatic cycle_drive(input bit v, input int d, input bit sof, output bit acc);
        pix_valid = v;
        pix_data  = DATA_W'(d);
        pix_sof   = sof;
        if (stall_req && !stall_done && stall_left == 0 && out_valid) begin
            stall_left = 5;
            held = out_data;
        end
        if (stall_left > 0) out_ready = 1'b0;
        else out_ready = ($urandom_range(99) < ready_pct);
        #1;
        if (stall_left > 0) begin
            chk("stall_pix_ready", {63'd0, pix_ready}, 64'd0);
            chk("stall_out_valid", {63'd0, out_valid}, 64'd1);
            chk("stall_hold_data", {32'd0, out_data}, {32'd0, held});
            stall_left--;
            if (stall_left == 0) stall_done = 1'b1;
        end
        acc = v && pix_ready;
        if (out_valid && out_ready) pop_check();
        @(posedge clk);
        #1;
        cyc++;
        if (!seen_first && out_valid) begin
            seen_first = 1'b1;
            first_cyc  = cyc;
        end
    endtask

    // Stream one frame (sof on its first pixel); optionally measure first-result latency.
    task automatic run_frame(input int bubble_pct, input bit check_lat);
        bit acc;
        int acc_cyc = 0;
        int guard;
        push_expected();
        seen_first = 1'b0;
        for (int p = 0; p < NPIX; p++) begin
            acc = 1'b0;
            guard = 0;
            while (!acc && guard < 200) begin
                cycle_drive(($urandom_range(99) >= bubble_pct), img[p], (p == 0), acc);
                guard++;
            end
            if (!acc) begin
                chk("accept_timeout", 64'd0, 64'd1);
                break;
            end
            if (p == (K - 1) * IMG_W + (K - 1)) acc_cyc = cyc;
        end
        if (check_lat) chk("first_latency", 64'(first_cyc - acc_cyc), 64'd2);
    endtask

    task automatic drain();
        bit acc;
        int guard = 0;
        while (exp_q.size() != 0 && guard < 300) begin
            cycle_drive(1'b0, 0, 1'b0, acc);
            guard++;
        end
        chk("drain_remaining", 64'(exp_q.size()), 64'd0);
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
    endtask

    task automatic write_coef(input int addr, input int val);
        coef_we   = 1'b1;
        coef_addr = 4'(addr);
        coef_data = COEF_W'(val);
        pix_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
        coef_we = 1'b0;
        if (addr < NTAP) coef_m[addr] = val;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
        chk({tag, "_out_data"},  {32'd0, out_data},  64'd0);
        chk({tag, "_out_last"},  {63'd0, out_last},  64'd0);
        chk({tag, "_pix_ready"}, {63'd0, pix_ready}, 64'd1);
    endtask

    initial begin
        bit acc;
        set_default_coefs();

        // Reset state.
        #12;
        check_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // All ones: four results of 14, latency and last flag.
        for (int p = 0; p < NPIX; p++) img[p] = 1;
        ready_pct = 100;
        run_frame(0, 1'b1);
        drain();

        // Ramp row*4+col: 70, 84, 126, 140.
        for (int p = 0; p < NPIX; p++) img[p] = p;
        run_frame(0, 1'b0);
        drain();

        // Ramp with a five-cycle output stall.
        stall_req = 1'b1;
        stall_done = 1'b0;
        run_frame(0, 1'b0);
        drain();
        chk("stall_happened", {63'd0, stall_done}, 64'd1);
        stall_req = 1'b0;

        // Centre tap only: 5, 6, 9, 10.
        for (int i = 0; i < NTAP; i++) write_coef(i, (i == 4) ? 1 : 0);
        run_frame(0, 1'b0);
        drain();

        // Out-of-range coefficient addresses are ignored.
        for (int a = NTAP; a < 16; a++) write_coef(a, 255);
        run_frame(0, 1'b0);
        drain();

        // Full scale: every result 585225.
        for (int i = 0; i < NTAP; i++) write_coef(i, 255);
        for (int p = 0; p < NPIX; p++) img[p] = 255;
        run_frame(0, 1'b0);
        drain();

        // Random coefficients, pixels, bubbles and back-pressure; frames back to back.
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < NTAP; i++) write_coef(i, $urandom_range(255));
            ready_pct = 60 + 10 * f;
            for (int g = 0; g < 2; g++) begin
                for (int p = 0; p < NPIX; p++) img[p] = $urandom_range(255);
                run_frame(25, 1'b0);
            end
            drain();
        end
        ready_pct = 100;

        // Reset mid-frame with non-default coefficients loaded.
        write_coef(0, 7);
        write_coef(4, 9);
        for (int p = 0; p < NPIX; p++) img[p] = p;
        for (int p = 0; p < 6; p++) cycle_drive(1'b1, img[p], (p == 0), acc);
        rst = 1'b1;
        #3;
        check_reset_outputs("midreset");
        exp_q.delete();
        exp_last_q.delete();
        set_default_coefs();
        pix_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            cycle_drive(1'b0, 0, 1'b0, acc);
            chk("no_stale_valid", {63'd0, out_valid}, 64'd0);
        end

        // Clean ramp frame after reset uses the restored defaults.
        run_frame(0, 1'b1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
